// File: rtl/zircon_ps2_mouse_receiver.sv
// PS/2 mouse receiver: frames 11-bit PS/2 bytes and assembles 3-byte movement packets.
// Optional parity enforcement is enabled with `define ZIRCON_PS2_PARITY_CHECK_EN.
module zircon_ps2_mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       csi_clk,
  input  logic       rsi_reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left_button,
  output logic       right_button,
  output logic       middle_button,
  output logic [8:0] x_increment,
  output logic [8:0] y_increment,
  output logic       packet_valid,
  output logic       frame_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  typedef enum logic [1:0] {B0, B1, B2} idx_t;

  logic          clk_s1_q, clk_s2_q, clk_dly_q;
  logic          dat_s1_q, dat_s2_q;
  state_t        state_q, state_d;
  idx_t          idx_q, idx_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [4:0]    b0_q, b0_d;     // {ysign, xsign, middle, right, left}
  logic [7:0]    b1_q, b1_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          left_q, left_d, right_q, right_d, mid_q, mid_d;
  logic [8:0]    x_q, x_d, y_q, y_d;
  logic          pv_q, pv_d, fe_q, fe_d;
`ifdef ZIRCON_PS2_PARITY_CHECK_EN
  logic          par_q, par_d;
`endif

  logic fall, din, timeout, byte_done, stop_ok;

  // Synchronizers idle high so reset release never looks like a falling edge.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_dly_q <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      clk_dly_q <= clk_s2_q;
      dat_s1_q  <= ps2_data;
      dat_s2_q  <= dat_s1_q;
    end
  end

  assign fall = clk_dly_q & ~clk_s2_q;
  assign din  = dat_s2_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    left_d    = left_q;
    right_d   = right_q;
    mid_d     = mid_q;
    x_d       = x_q;
    y_d       = y_q;
    pv_d      = 1'b0;
    fe_d      = 1'b0;
    byte_done = 1'b0;
    stop_ok   = 1'b0;
`ifdef ZIRCON_PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif

    timeout  = !fall && (to_cnt_q == TO_MAX) && ((state_q != IDLE) || (idx_q != B0));
    to_cnt_d = fall ? '0 : ((to_cnt_q != TO_MAX) ? to_cnt_q + 1'b1 : to_cnt_q);

    case (state_q)
      IDLE: if (fall) begin
        if (!din) begin
          state_d = DATA;
          bcnt_d  = 3'd0;
        end else begin
          fe_d = 1'b1;
        end
      end
      DATA: if (fall) begin
        shift_d = {din, shift_q[7:1]};
        bcnt_d  = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
`ifdef ZIRCON_PS2_PARITY_CHECK_EN
        par_d   = din;
`endif
        state_d = STOP;
      end
      STOP: if (fall) begin
`ifdef ZIRCON_PS2_PARITY_CHECK_EN
        stop_ok = din & (^shift_q ^ par_q);
`else
        stop_ok = din;
`endif
        state_d = IDLE;
        if (stop_ok) byte_done = 1'b1;
        else         fe_d      = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (byte_done) begin
      case (idx_q)
        B0: if (shift_q[3]) begin
          b0_d  = {shift_q[5], shift_q[4], shift_q[2:0]};
          idx_d = B1;
        end
        B1: begin
          b1_d  = shift_q;
          idx_d = B2;
        end
        B2: begin
          left_d  = b0_q[0];
          right_d = b0_q[1];
          mid_d   = b0_q[2];
          x_d     = {b0_q[3], b1_q};
          y_d     = {b0_q[4], shift_q};
          pv_d    = 1'b1;
          idx_d   = B0;
        end
        default: idx_d = B0;
      endcase
    end

    // A timeout can only fire on a cycle without an edge, so it never races byte_done.
    if (timeout) begin
      state_d = IDLE;
      idx_d   = B0;
      fe_d    = (state_q != IDLE);
    end
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_q  <= IDLE;
      idx_q    <= B0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      to_cnt_q <= '0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      mid_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      pv_q     <= 1'b0;
      fe_q     <= 1'b0;
`ifdef ZIRCON_PS2_PARITY_CHECK_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      to_cnt_q <= to_cnt_d;
      left_q   <= left_d;
      right_q  <= right_d;
      mid_q    <= mid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pv_q     <= pv_d;
      fe_q     <= fe_d;
`ifdef ZIRCON_PS2_PARITY_CHECK_EN
      par_q    <= par_d;
`endif
    end
  end

  assign left_button   = left_q;
  assign right_button  = right_q;
  assign middle_button = mid_q;
  assign x_increment   = x_q;
  assign y_increment   = y_q;
  assign packet_valid  = pv_q;
  assign frame_error   = fe_q;

endmodule

// File: tb/tb_zircon_ps2_mouse_receiver.sv
// Directed bench for zircon_ps2_mouse_receiver: packets, resync, bad frames, timeouts, reset.
module tb_zircon_ps2_mouse_receiver;

  localparam int TO = 200;

  logic       clk, rst, pclk, pdat;
  logic       lb, rb, mb, pv, fe;
  logic [8:0] xi, yi;

  int n_chk = 0;
  int n_err = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;
  int pv0, fe0;

  zircon_ps2_mouse_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .csi_clk(clk), .rsi_reset(rst), .ps2_clk(pclk), .ps2_data(pdat),
    .left_button(lb), .right_button(rb), .middle_button(mb),
    .x_increment(xi), .y_increment(yi),
    .packet_valid(pv), .frame_error(fe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pv) pv_cnt++;
      if (fe) fe_cnt++;
      if (pv || fe) chk("pv_fe_excl", {31'd0, pv & fe}, 32'd0);
    end
  end

  task automatic ps2_bit(input logic v);
    pdat = v;
    repeat (10) @(posedge clk);
    pclk = 1'b0;
    repeat (10) @(posedge clk);
    pclk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par_ok, input logic stop_v);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par_ok ? ~^b : ^b);
    ps2_bit(stop_v);
    pdat = 1'b1;
  endtask

  task automatic snap();
    pv0 = pv_cnt;
    fe0 = fe_cnt;
  endtask

  task automatic chk_pkt(input string tag, input int npv, input int nfe,
                         input logic l, input logic r, input logic m,
                         input logic [8:0] x, input logic [8:0] y);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk({tag, "_pv"},  pv_cnt - pv0, npv);
    chk({tag, "_fe"},  fe_cnt - fe0, nfe);
    chk({tag, "_l"},   {31'd0, lb}, {31'd0, l});
    chk({tag, "_r"},   {31'd0, rb}, {31'd0, r});
    chk({tag, "_m"},   {31'd0, mb}, {31'd0, m});
    chk({tag, "_x"},   {23'd0, xi}, {23'd0, x});
    chk({tag, "_y"},   {23'd0, yi}, {23'd0, y});
  endtask

  initial begin
    rst = 1'b1; pclk = 1'b1; pdat = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {19'd0, lb, rb, mb, xi, yi, pv, fe}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // basic packet
    snap();
    send_byte(8'h09, 1'b1, 1'b1); send_byte(8'h05, 1'b1, 1'b1); send_byte(8'hFB, 1'b1, 1'b1);
    chk_pkt("pkt1", 1, 0, 1'b1, 1'b0, 1'b0, 9'h005, 9'h0FB);

    // negative motion
    snap();
    send_byte(8'h39, 1'b1, 1'b1); send_byte(8'hFE, 1'b1, 1'b1); send_byte(8'h80, 1'b1, 1'b1);
    chk_pkt("neg", 1, 0, 1'b1, 1'b0, 1'b0, 9'h1FE, 9'h180);

    // resync: 0x00 lacks bit3 and is dropped silently
    snap();
    send_byte(8'h00, 1'b1, 1'b1);
    send_byte(8'h0A, 1'b1, 1'b1); send_byte(8'h01, 1'b1, 1'b1); send_byte(8'h02, 1'b1, 1'b1);
    chk_pkt("resync", 1, 0, 1'b0, 1'b1, 1'b0, 9'h001, 9'h002);

    // bad parity on the leading byte
    snap();
    send_byte(8'h09, 1'b0, 1'b1);
`ifdef ZIRCON_PS2_PARITY_CHECK_EN
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("par_fe", fe_cnt - fe0, 1);
    chk("par_hold_x", {23'd0, xi}, 32'h001);
    snap();
    send_byte(8'h0C, 1'b1, 1'b1); send_byte(8'h03, 1'b1, 1'b1); send_byte(8'h04, 1'b1, 1'b1);
    chk_pkt("par_next", 1, 0, 1'b0, 1'b0, 1'b1, 9'h003, 9'h004);
`else
    // 0x09 accepted as byte0; 0x0C, 0x03 complete it; 0x04 is then dropped at B0
    send_byte(8'h0C, 1'b1, 1'b1); send_byte(8'h03, 1'b1, 1'b1); send_byte(8'h04, 1'b1, 1'b1);
    chk_pkt("par_ign", 1, 0, 1'b1, 1'b0, 1'b0, 9'h00C, 9'h003);
`endif

    // bad stop bit, then an isolated edge with data high (bad start)
    snap();
    send_byte(8'h09, 1'b1, 1'b0);
    ps2_bit(1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("badframe_fe", fe_cnt - fe0, 2);
    chk("badframe_pv", pv_cnt - pv0, 0);

    // timeout between bytes: no error, index back to B0
    snap();
    send_byte(8'h08, 1'b1, 1'b1);
    repeat (TO + 10) @(posedge clk);
    send_byte(8'h09, 1'b1, 1'b1); send_byte(8'h07, 1'b1, 1'b1); send_byte(8'h06, 1'b1, 1'b1);
    chk_pkt("to_idx", 1, 0, 1'b1, 1'b0, 1'b0, 9'h007, 9'h006);

    // timeout mid-byte: one error, outputs held
    snap();
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    pdat = 1'b1;
    repeat (TO + 10) @(posedge clk);
    chk_pkt("to_mid", 0, 1, 1'b1, 1'b0, 1'b0, 9'h007, 9'h006);

    // reset during byte1 data bits
    send_byte(8'h09, 1'b1, 1'b1);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    pdat = 1'b1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_outs", {19'd0, lb, rb, mb, xi, yi, pv, fe}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    snap();
    send_byte(8'h0B, 1'b1, 1'b1); send_byte(8'h10, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst_partial_pv", pv_cnt - pv0, 0);
    send_byte(8'h20, 1'b1, 1'b1);
    chk_pkt("rst_pkt", 1, 0, 1'b1, 1'b1, 1'b0, 9'h010, 9'h020);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
